// File: rtl/rca_seq_ctrl_if.sv
// Request/result handshake bundle for rca_seq_ctrl.
// Optional ovf signal exists only when RCA_SEQ_OVF_EN is defined.
interface rca_seq_ctrl_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef RCA_SEQ_OVF_EN
  logic             ovf;
`endif

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef RCA_SEQ_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef RCA_SEQ_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/rca_seq_ctrl.sv
// WIDTH-bit adder sequenced through one 4-bit ripple slice, LS nibble first.
// Define RCA_SEQ_OVF_EN to add the registered signed-overflow output ovf.
module rcadder_4 (
  output logic [3:0] sum,
  output logic       carryout,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       CarryIn
);
  logic [4:0] c;
  assign c[0] = CarryIn;
  for (genvar k = 0; k < 4; k++) begin : g_fa
    assign sum[k]  = A[k] ^ B[k] ^ c[k];
    assign c[k+1]  = (A[k] & B[k]) | (c[k] & (A[k] ^ B[k]));
  end
  assign carryout = c[4];
endmodule

module rca_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input logic           clk,
  input logic           rst_n,
  rca_seq_ctrl_if.slave bus
);
  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [NSLICE-1:0][3:0] op_a, op_b, sum_r;
  logic [CW-1:0]          cnt;
  logic                   carry, cout_r;
  logic [3:0]             sl_a, sl_b, sl_sum;
  logic                   sl_co;

  assign sl_a = op_a[cnt];
  assign sl_b = op_b[cnt];

  rcadder_4 u_slice (
    .sum      (sl_sum),
    .carryout (sl_co),
    .A        (sl_a),
    .B        (sl_b),
    .CarryIn  (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (cnt == LAST)   state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

`ifdef RCA_SEQ_OVF_EN
  // Carry into bit 3 of the slice recovered from its sum bit; only used on the top slice.
  logic c_top, ovf_r;
  assign c_top   = sl_a[3] ^ sl_b[3] ^ sl_sum[3];
  assign bus.ovf = ovf_r;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      sum_r  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf_r  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (bus.in_valid) begin
          op_a  <= bus.a;
          op_b  <= bus.b;
          carry <= bus.cin;
          cnt   <= '0;
        end
        RUN: begin
          sum_r[cnt] <= sl_sum;
          carry      <= sl_co;
          if (cnt == LAST) begin
            cout_r <= sl_co;
            cnt    <= '0;
`ifdef RCA_SEQ_OVF_EN
            ovf_r  <= c_top ^ sl_co;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
endmodule
